// File: rtl/wave_pkg.sv
// Shared constants and selector encodings for wave_timebase and wave_generator.
package wave_pkg;

    localparam int unsigned WAVE_W = 8;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned CODE_W = 4;
    localparam int unsigned DIV_W  = 16;

    typedef enum logic [SEL_W-1:0] {
        SEL_RHOMBOID = 3'd0,
        SEL_SINE     = 3'd1,
        SEL_SQUARE   = 3'd2,
        SEL_RECIP    = 3'd3,
        SEL_SAW      = 3'd4,
        SEL_FWR      = 3'd5,
        SEL_MODSQ    = 3'd6
    } sel_e;

    // Divide value for a frequency code, floored at 1. A base of 2^16 at code 0
    // truncates to 0, which the prescaler's wrapping compare treats as 65536.
    function automatic logic [DIV_W-1:0] calc_div(input int unsigned base,
                                                   input logic [CODE_W-1:0] code);
        int unsigned shifted;
        shifted = base >> code;
        if (shifted == 0) begin
            shifted = 1;
        end
        return DIV_W'(shifted);
    endfunction

endpackage

// File: rtl/wave_prescaler.sv
// Prescaler: counts 0..div-1 while enabled and flags the terminal count.
module wave_prescaler
    import wave_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    output logic             step_c
);

    logic [DIV_W-1:0] presc_q;
    logic [DIV_W-1:0] presc_d;
    logic             terminal_c;

    // div-1 wraps to all-ones for div=0, giving a full 2^16 count.
    assign terminal_c = (presc_q == (div - DIV_W'(1)));
    assign step_c     = enable && terminal_c;

    // Next count: advance while enabled, restart after the terminal count.
    always_comb begin
        presc_d = presc_q;
        if (enable) begin
            presc_d = terminal_c ? '0 : presc_q + DIV_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/wave_timebase.sv
// Phase/selector timebase for wave_generator; frequency and waveform changes
// are held pending and applied only on the 255->0 phase wrap.
module wave_timebase
    import wave_pkg::*;
#(
    parameter int unsigned      DIV_BASE  = 1024,
    parameter int unsigned      CODE_MAX  = 10,
    parameter logic [SEL_W-1:0] SEL_RESET = 3'b000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              freq_up,
    input  logic              freq_down,
    input  logic [SEL_W-1:0]  sel_in,
    input  logic              sel_load,
    output logic [WAVE_W-1:0] wavecnt,
    output logic [SEL_W-1:0]  selector,
    output logic              step_tick,
    output logic              wrap_tick,
    output logic [CODE_W-1:0] freq_code
);

    localparam logic [CODE_W-1:0] CODE_TOP = CODE_W'(CODE_MAX);

    logic [WAVE_W-1:0] wavecnt_q,      wavecnt_d;
    logic [SEL_W-1:0]  selector_q,     selector_d;
    logic [CODE_W-1:0] freq_code_q,    freq_code_d;
    logic [CODE_W-1:0] pending_code_q, pending_code_d;
    logic [SEL_W-1:0]  pending_sel_q,  pending_sel_d;
    logic              step_tick_q;
    logic              wrap_tick_q;

    logic [DIV_W-1:0]  div_c;
    logic              step_c;
    logic              wrap_c;

    // Divide value always follows the applied code, never the pending one.
    assign div_c = calc_div(DIV_BASE, freq_code_q);

    wave_prescaler u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .div    (div_c),
        .step_c (step_c)
    );

    // Pending requests: saturating code adjust, last selector load wins.
    always_comb begin
        pending_code_d = pending_code_q;
        pending_sel_d  = pending_sel_q;
        if (freq_up && !freq_down) begin
            if (pending_code_q < CODE_TOP) begin
                pending_code_d = pending_code_q + CODE_W'(1);
            end
        end else if (freq_down && !freq_up) begin
            if (pending_code_q != '0) begin
                pending_code_d = pending_code_q - CODE_W'(1);
            end
        end
        if (sel_load) begin
            pending_sel_d = sel_in;
        end
    end

    // Phase advance and wrap commit; same-cycle requests join the commit.
    always_comb begin
        wavecnt_d   = wavecnt_q;
        freq_code_d = freq_code_q;
        selector_d  = selector_q;
        wrap_c      = step_c && (wavecnt_q == '1);
        if (step_c) begin
            wavecnt_d = wavecnt_q + WAVE_W'(1);
        end
        if (wrap_c) begin
            freq_code_d = pending_code_d;
            selector_d  = pending_sel_d;
        end
    end

    // Pending request registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_code_q <= '0;
            pending_sel_q  <= SEL_RESET;
        end else begin
            pending_code_q <= pending_code_d;
            pending_sel_q  <= pending_sel_d;
        end
    end

    // Applied state and tick registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wavecnt_q   <= '0;
            selector_q  <= SEL_RESET;
            freq_code_q <= '0;
            step_tick_q <= 1'b0;
            wrap_tick_q <= 1'b0;
        end else begin
            wavecnt_q   <= wavecnt_d;
            selector_q  <= selector_d;
            freq_code_q <= freq_code_d;
            step_tick_q <= step_c;
            wrap_tick_q <= wrap_c;
        end
    end

    assign wavecnt   = wavecnt_q;
    assign selector  = selector_q;
    assign freq_code = freq_code_q;
    assign step_tick = step_tick_q;
    assign wrap_tick = wrap_tick_q;

endmodule

// File: tb/tb_wave_timebase.sv
// Self-checking bench for wave_timebase with a step-event scoreboard.
module tb_wave_timebase;

    localparam int unsigned DIV = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       freq_up = 1'b0;
    logic       freq_down = 1'b0;
    logic [2:0] sel_in = 3'd0;
    logic       sel_load = 1'b0;
    logic [7:0] wavecnt;
    logic [2:0] selector;
    logic       step_tick;
    logic       wrap_tick;
    logic [3:0] freq_code;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int unsigned gap;
        logic [7:0]  wc;
        logic [2:0]  sel;
        logic [3:0]  code;
        logic        wrap;
    } exp_t;

    exp_t sb[$];

    int unsigned cyc_cnt = 0;
    int unsigned last_cyc = 0;
    int unsigned mon_gap;
    exp_t        mon_e;

    wave_timebase #(
        .DIV_BASE  (DIV),
        .CODE_MAX  (10),
        .SEL_RESET (3'b000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .freq_up   (freq_up),
        .freq_down (freq_down),
        .sel_in    (sel_in),
        .sel_load  (sel_load),
        .wavecnt   (wavecnt),
        .selector  (selector),
        .step_tick (step_tick),
        .wrap_tick (wrap_tick),
        .freq_code (freq_code)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every step tick pops one expected event.
    always @(posedge clk) begin
        #1;
        cyc_cnt = cyc_cnt + 1;
        if (!rst) begin
            last_cyc = cyc_cnt;
        end else begin
            n_cmp++;
            if (wrap_tick && !step_tick) begin
                n_err++;
                $display("FAIL wrap_alone: wrap_tick=1 with step_tick=0 at cycle %0d", cyc_cnt);
            end
            if (step_tick) begin
                n_cmp++;
                mon_gap = cyc_cnt - last_cyc;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_step: wavecnt=%0d at cycle %0d, required no step", wavecnt, cyc_cnt);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_gap !== mon_e.gap || wavecnt !== mon_e.wc || selector !== mon_e.sel ||
                        freq_code !== mon_e.code || wrap_tick !== mon_e.wrap) begin
                        n_err++;
                        $display("FAIL step_event: got gap=%0d wc=%0d sel=%0d code=%0d wrap=%0d, required gap=%0d wc=%0d sel=%0d code=%0d wrap=%0d",
                                 mon_gap, wavecnt, selector, freq_code, wrap_tick,
                                 mon_e.gap, mon_e.wc, mon_e.sel, mon_e.code, mon_e.wrap);
                    end
                end
                last_cyc = cyc_cnt;
            end
        end
    end

    // Queue the expected step events for phases from_n..to_n (values mod 256).
    task automatic push_run(input int from_n, input int to_n, input int unsigned gap,
                            input int unsigned first_gap, input logic [2:0] sel,
                            input logic [3:0] code, input logic [2:0] wsel, input logic [3:0] wcode);
        exp_t e;
        for (int n = from_n; n <= to_n; n++) begin
            e.gap  = (n == from_n) ? first_gap : gap;
            e.wc   = 8'(n % 256);
            e.wrap = ((n % 256) == 0);
            e.sel  = e.wrap ? wsel : sel;
            e.code = e.wrap ? wcode : code;
            sb.push_back(e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (wavecnt !== 8'd0) begin n_err++; $display("FAIL reset_wavecnt: got %0d required 0", wavecnt); end
        n_cmp++; if (selector !== 3'd0) begin n_err++; $display("FAIL reset_selector: got %0d required 0", selector); end
        n_cmp++; if (freq_code !== 4'd0) begin n_err++; $display("FAIL reset_code: got %0d required 0", freq_code); end
        n_cmp++; if (step_tick !== 1'b0) begin n_err++; $display("FAIL reset_step: got %0d required 0", step_tick); end
        n_cmp++; if (wrap_tick !== 1'b0) begin n_err++; $display("FAIL reset_wrap: got %0d required 0", wrap_tick); end
        rst = 1'b1;
    endtask

    task automatic test_free_run();
        push_run(1, 256, DIV, DIV, 3'd0, 4'd0, 3'd0, 4'd0);
        for (int i = 0; i < 5000 && sb.size() != 0; i++) @(negedge clk);
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL free_run_drain: %0d pending, required 0", sb.size()); sb.delete(); end
        n_cmp++; if (wavecnt !== 8'd0) begin n_err++; $display("FAIL free_run_wc: got %0d required 0", wavecnt); end
    endtask

    task automatic test_freq_up();
        push_run(1, 100, DIV, DIV, 3'd0, 4'd0, 3'd0, 4'd0);
        for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL up_reach100: %0d pending, required 0", sb.size()); sb.delete(); end
        push_run(101, 256, DIV, DIV, 3'd0, 4'd0, 3'd0, 4'd3);
        push_run(1, 256, 2, 2, 3'd0, 4'd3, 3'd0, 4'd3);
        for (int p = 0; p < 3; p++) begin
            freq_up = 1'b1;
            @(negedge clk);
            n_cmp++; if (freq_code !== 4'd0) begin n_err++; $display("FAIL up_deferred: got %0d required 0", freq_code); end
            freq_up = 1'b0;
            @(negedge clk);
        end
        for (int i = 0; i < 4000 && sb.size() != 0; i++) @(negedge clk);
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL up_drain: %0d pending, required 0", sb.size()); sb.delete(); end
        n_cmp++; if (freq_code !== 4'd3) begin n_err++; $display("FAIL up_applied: got %0d required 3", freq_code); end
    endtask

    task automatic test_saturate();
        push_run(1, 256, 2, 2, 3'd0, 4'd3, 3'd0, 4'd10);
        push_run(1, 256, 1, 1, 3'd0, 4'd10, 3'd0, 4'd0);
        for (int p = 0; p < 15; p++) begin
            freq_up = 1'b1;
            @(negedge clk);
            freq_up = 1'b0;
            @(negedge clk);
        end
        for (int i = 0; i < 1000 && freq_code !== 4'd10; i++) @(negedge clk);
        n_cmp++; if (freq_code !== 4'd10) begin n_err++; $display("FAIL sat_code: got %0d required 10", freq_code); end
        for (int p = 0; p < 12; p++) begin
            freq_down = 1'b1;
            @(negedge clk);
            n_cmp++; if (step_tick !== 1'b1) begin n_err++; $display("FAIL sat_step_held: got %0d required 1", step_tick); end
            freq_down = 1'b0;
            @(negedge clk);
            n_cmp++; if (step_tick !== 1'b1) begin n_err++; $display("FAIL sat_step_held: got %0d required 1", step_tick); end
        end
        for (int i = 0; i < 1000 && sb.size() != 0; i++) @(negedge clk);
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL sat_drain: %0d pending, required 0", sb.size()); sb.delete(); end
        n_cmp++; if (freq_code !== 4'd0) begin n_err++; $display("FAIL sat_down_code: got %0d required 0", freq_code); end
    endtask

    task automatic test_selector();
        push_run(1, 50, DIV, DIV, 3'd0, 4'd0, 3'd0, 4'd0);
        for (int i = 0; i < 1000 && sb.size() != 0; i++) @(negedge clk);
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL sel_reach50: %0d pending, required 0", sb.size()); sb.delete(); end
        sel_in = 3'd3;
        sel_load = 1'b1;
        push_run(51, 200, DIV, DIV, 3'd0, 4'd0, 3'd0, 4'd0);
        @(negedge clk);
        sel_load = 1'b0;
        n_cmp++; if (selector !== 3'd0) begin n_err++; $display("FAIL sel_deferred: got %0d required 0", selector); end
        for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL sel_reach200: %0d pending, required 0", sb.size()); sb.delete(); end
        sel_in = 3'd5;
        sel_load = 1'b1;
        push_run(201, 256, DIV, DIV, 3'd0, 4'd0, 3'd5, 4'd0);
        @(negedge clk);
        sel_load = 1'b0;
        sel_in = 3'd0;
        for (int i = 0; i < 1000 && sb.size() != 0; i++) @(negedge clk);
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL sel_drain: %0d pending, required 0", sb.size()); sb.delete(); end
        n_cmp++; if (selector !== 3'd5) begin n_err++; $display("FAIL sel_applied: got %0d required 5", selector); end
    endtask

    task automatic test_enable();
        // Four enabled edges, 500 frozen, then twelve more to finish the step.
        push_run(1, 1, DIV, DIV + 500, 3'd5, 4'd0, 3'd5, 4'd0);
        push_run(2, 256, DIV, DIV, 3'd5, 4'd0, 3'd5, 4'd1);
        repeat (4) @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 500; i++) begin
            freq_up   = (i == 10) || (i == 20);
            freq_down = (i == 20);
            @(negedge clk);
            n_cmp++; if (wavecnt !== 8'd0) begin n_err++; $display("FAIL hold_wc: got %0d required 0", wavecnt); end
            n_cmp++; if (step_tick !== 1'b0 || wrap_tick !== 1'b0) begin
                n_err++; $display("FAIL hold_ticks: got step=%0d wrap=%0d required 0/0", step_tick, wrap_tick);
            end
        end
        freq_up = 1'b0;
        freq_down = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 5000 && sb.size() != 0; i++) @(negedge clk);
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL en_drain: %0d pending, required 0", sb.size()); sb.delete(); end
        n_cmp++; if (freq_code !== 4'd1) begin n_err++; $display("FAIL en_code: got %0d required 1", freq_code); end
    endtask

    task automatic test_reset_mid();
        push_run(1, 3, 8, 8, 3'd5, 4'd1, 3'd5, 4'd1);
        freq_up = 1'b1;
        sel_in = 3'd4;
        sel_load = 1'b1;
        @(negedge clk);
        freq_up = 1'b0;
        sel_load = 1'b0;
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL rm_pre: %0d pending, required 0", sb.size()); sb.delete(); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (wavecnt !== 8'd0) begin n_err++; $display("FAIL rm_wavecnt: got %0d required 0", wavecnt); end
        n_cmp++; if (selector !== 3'd0) begin n_err++; $display("FAIL rm_selector: got %0d required 0", selector); end
        n_cmp++; if (freq_code !== 4'd0) begin n_err++; $display("FAIL rm_code: got %0d required 0", freq_code); end
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        push_run(1, 256, DIV, DIV, 3'd0, 4'd0, 3'd0, 4'd0);
        for (int i = 0; i < 5000 && sb.size() != 0; i++) @(negedge clk);
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL rm_drain: %0d pending, required 0", sb.size()); sb.delete(); end
        n_cmp++; if (freq_code !== 4'd0 || selector !== 3'd0) begin
            n_err++; $display("FAIL rm_stale: got code=%0d sel=%0d required 0/0", freq_code, selector);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_freq_up();
        test_saturate();
        test_selector();
        test_enable();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wave_timebase.md
Name: wave_timebase

Overview:
Upstream timebase for wave_generator. Produces the 8-bit phase count `wavecnt` and the 3-bit waveform `selector` that wave_generator consumes. Output frequency is set by a prescaler whose divide value comes from a saturating frequency code, adjusted by up/down pulses. Frequency and waveform changes are deferred to the phase wrap (255->0), so a waveform period is never torn.

Parameters:
DIV_BASE, 1024, prescaler divide value at freq_code=0 (clk cycles per wavecnt step); must be a power of two, at most 2^16.
CODE_MAX, 10, maximum freq_code; divide value = DIV_BASE >> freq_code, floored at 1.
SEL_RESET, 3'b000, selector value after reset (Rhomboid).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
enable  input  1  1 = prescaler runs; 0 = all counters hold
freq_up  input  1  single-cycle pulse; request freq_code+1
freq_down  input  1  single-cycle pulse; request freq_code-1
sel_in  input  3  requested waveform
sel_load  input  1  single-cycle pulse; capture sel_in as pending selector
wavecnt  output  8  phase count to wave_generator
selector  output  3  active waveform select to wave_generator
step_tick  output  1  1-cycle pulse on each wavecnt increment
wrap_tick  output  1  1-cycle pulse when wavecnt goes 255->0
freq_code  output  4  currently applied frequency code

Behaviour:
- Reset (rst=0, async): wavecnt=0, selector=SEL_RESET, freq_code=0, pending_code=0, pending_sel=SEL_RESET, presc=0, step_tick=0, wrap_tick=0. All registers update on the clk rising edge only after rst returns to 1.
- Prescaler: presc counts 0..div-1, where div = max(1, DIV_BASE >> freq_code), computed from the applied freq_code, not the pending one.
  - When presc == div-1 and enable=1: presc<=0, wavecnt<=wavecnt+1 (mod 256), step_tick=1 in the following cycle (registered).
- enable=0: presc, wavecnt and the tick outputs hold/clear (ticks=0). Pending requests are still captured.
- Frequency request:
  - freq_up: pending_code<=min(pending_code+1, CODE_MAX).
  - freq_down: pending_code<=max(pending_code-1, 0).
  - freq_up and freq_down in the same cycle: no change.
  - Multiple pulses before a wrap accumulate, with saturation.
- Selector request: sel_load=1 -> pending_sel<=sel_in. The last load before a wrap wins.
- Wrap commit: on the step where wavecnt goes 255->0:
  - freq_code<=pending_code and selector<=pending_sel, in the same cycle wavecnt becomes 0.
  - wrap_tick pulses in the cycle after, aligned with step_tick.
  - A request arriving in the same cycle as the wrap step is included in that commit (next-state value is used).
- freq_code output always reflects the applied code, never the pending one.
- div=1 (freq_code large enough): wavecnt increments every enabled cycle and step_tick is continuously high.
- Latency: wavecnt changes exactly div enabled cycles after the previous change.
- Reset mid-period: all state returns to reset values immediately; pending requests are discarded.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package (wave_pkg): selector encodings (SEL_RHOMBOID=0, SEL_SINE=1, SEL_SQUARE=2, SEL_RECIP=3, SEL_SAW=4, SEL_FWR=5, SEL_MODSQ=6), plus the WAVE_W=8 and SEL_W=3 constants, all shared with wave_generator.
- One sub-module: wave_prescaler (clk, rst, enable, div[15:0] -> step pulse). It holds the presc counter and the terminal-count compare.
- Request latching and wrap commit stay in the top module.

Test Plan:
- Reset + free run, DIV_BASE=1024, code 0: after rst deasserts, wavecnt=1 at exactly 1024 cycles and 255 at 261120 cycles; wrap_tick once at 262144 cycles; selector=0 throughout.
- 3 freq_up pulses at wavecnt=100 -> freq_code stays 0 until the wrap, then 3; next step interval=128 cycles; wrap_tick period=32768 cycles.
- 15 freq_up pulses -> saturates: applied freq_code=10, div=1, step_tick held 1, wavecnt increments every cycle. Then 12 freq_down pulses -> code 0 after the next wrap.
- Two sel_load pulses at wavecnt=50 (sel_in=3) then wavecnt=200 (sel_in=5) -> selector stays 0 until the wrap, then 5 in the same cycle wavecnt=0.
- enable=0 for 500 cycles mid-step -> wavecnt and presc frozen, no ticks; resume completes the remaining presc count. freq_up+freq_down in the same cycle -> pending unchanged.
- rst pulsed low asynchronously mid-period with pending code=2 and sel=4 -> outputs immediately 0/SEL_RESET/0; after release, no stale commit at the first wrap.
